flash_line_prefetcher: RTL
==========================

// Module: flash_line_prefetcher
// PURPOSE
//  Next-line prefetch stage between the AHB flash cache controller (upstream, line-fill requester)
//  and the quad-I/O flash line reader (downstream). After each demand fill of line L, it reads
//  line L+1 into a one-line buffer. A following miss to L+1 is then served in 1 cycle instead of
//  a full flash read. Both sides use the same rd-pulse / done-pulse line-fill protocol.
// PARAMETERS
//  LINE_SIZE  128  line width in bits (128 or 256); LINE_BYTES=LINE_SIZE/8, OFS=log2(LINE_BYTES)
//  PF_ENABLE  1    1: prefetch active; 0: pure pass-through (every request goes to flash)
// PORTS
//  HCLK       in   1          clock
//  HRESETn    in   1          reset, asynchronous, active-low
//  req_addr   in   24         upstream fill byte address; only [23:OFS] is used
//  req_rd     in   1          upstream 1-cycle request pulse
//  req_done   out  1          1-cycle pulse: req_line holds the requested line
//  req_line   out  LINE_SIZE  line returned to upstream (registered)
//  fr_addr    out  24         downstream read address, {line,OFS'b0} (registered)
//  fr_rd      out  1          downstream 1-cycle read pulse (registered)
//  fr_done    in   1          downstream 1-cycle completion pulse
//  fr_line    in   LINE_SIZE  downstream line; valid while fr_done=1
//  pf_hit     out  1          1-cycle pulse: the request was served from the prefetch buffer
// BEHAVIOUR
//  Reset: req_done=0, req_line=0, fr_addr=0, fr_rd=0, pf_hit=0, pf_valid=0, pend=0, state=IDLE.
//   Reset mid-read discards all in-flight and buffered data (the reader shares HRESETn).
//  Internal regs: pf_tag[23:OFS], pf_line, pf_valid; pend/pend_tag latch a request that arrives while busy.
//  req_line holds its value from req_done until the next capture. Upstream writes its cache 1 cycle after req_done.
//  Downstream rule: at most one outstanding read. fr_rd fires no earlier than 2 cycles after the previous fr_done.
//  FSM states: IDLE, DEM (demand read in flight), DGAP, PREF (prefetch in flight), PGAP.
//  IDLE, req_rd or pend set (tag T = req_addr[23:OFS] or pend_tag), clear pend:
//   - PF_ENABLE & pf_valid & pf_tag==T: next cycle req_line<=pf_line, req_done=1, pf_hit=1.
//     Then issue a prefetch of T+1 on the following cycle; go to PREF.
//   - otherwise: next cycle fr_rd=1, fr_addr={T,0}, pf_valid<=0; go to DEM.
//  DEM: on fr_done, req_line<=fr_line. req_done=1 the next cycle; go to DGAP.
//  DGAP (1 cycle): if PF_ENABLE and T+1 does not wrap past 24'hFFFFFF, issue a prefetch
//   (fr_rd=1, fr_addr={T+1,0}) and go to PREF. Otherwise go to IDLE.
//  PREF: on fr_done, pf_line<=fr_line, pf_tag<=T+1, pf_valid<=1; go to PGAP.
//  PGAP (1 cycle): go to IDLE. A pending request is handled there, so a hit on the fresh line is legal.
//  req_rd during DEM/DGAP cannot occur (upstream blocks). If it does, it is latched in pend.
//  req_rd during PREF/PGAP: latched in pend. Prefetch reads are never aborted.
//   A matching pend is served on completion, a non-matching one after it.
//  req_rd in the same cycle as fr_done: both are honoured (line captured, request latched).
//  Latencies (req_rd in cycle 0):
//   - hit: req_done in cycle 1.
//   - miss from IDLE: fr_rd in cycle 1, req_done the cycle after fr_done.
//  Tag arithmetic is modulo 2^(24-OFS). The wrap case suppresses the prefetch and does not wrap to line 0.
//  PF_ENABLE=0: pf_valid stays 0 and pf_hit never fires. Only IDLE/DEM/DGAP are used.
// TESTING
//  1 Cold miss: req_rd @0x000100 -> fr_rd, fr_addr=0x000100. Model fr_done after 52 cyc -> req_done +1 cyc,
//    correct line. Then fr_rd for 0x000110 exactly 2 cyc after req_done.
//  2 Sequential hit: after 1 completes, req_rd @0x000114 -> req_done+pf_hit next cycle with line 0x000110.
//    Then prefetch fr_addr=0x000120.
//  3 Request during prefetch, non-match: req_rd @0x004000 while PREF busy -> no fr_rd until prefetch fr_done.
//    Then demand fr_addr=0x004000, correct data, pf_valid=0 after.
//  4 Request during prefetch, match: req_rd @0x000120 while prefetching 0x000120 -> no extra fr_rd.
//    req_done+pf_hit in the IDLE cycle after PGAP.
//  5 Boundary: miss @0xFFFFF0 -> demand served, no prefetch issued. PF_ENABLE=0 build: every req -> fr_rd, pf_hit=0.
//  6 Reset mid-PREF: assert HRESETn=0 -> all outputs 0 asynchronously.
//    Re-request of the prefetched line after release -> full flash read (no hit).

Source files
------------

// File: rtl/flash_line_prefetcher.sv
// Next-line prefetch stage between the flash cache controller and the flash line reader.
// After each demand fill of line L it fetches L+1 into a one-line buffer for single-cycle hits.
module flash_line_prefetcher #(
  parameter int unsigned LINE_SIZE = 128,
  parameter bit          PF_ENABLE = 1'b1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [23:0]          req_addr,
  input  logic                 req_rd,
  output logic                 req_done,
  output logic [LINE_SIZE-1:0] req_line,
  output logic [23:0]          fr_addr,
  output logic                 fr_rd,
  input  logic                 fr_done,
  input  logic [LINE_SIZE-1:0] fr_line,
  output logic                 pf_hit
);

  localparam int unsigned LineBytes = LINE_SIZE / 8;
  localparam int unsigned Ofs       = $clog2(LineBytes);
  localparam int unsigned TagW      = 24 - Ofs;

  typedef enum logic [2:0] {
    StIdle,
    StDem,
    StDgap,
    StPref,
    StPgap
  } state_e;

  state_e                 state_q;
  logic                   gap_wait_q;
  logic [TagW-1:0]        cur_tag_q;
  logic [TagW-1:0]        pf_tag_q;
  logic [LINE_SIZE-1:0]   pf_line_q;
  logic                   pf_valid_q;
  logic                   pend_q;
  logic [TagW-1:0]        pend_tag_q;

  logic [TagW-1:0]        req_tag;
  logic [TagW-1:0]        sel_tag;
  logic [TagW-1:0]        next_tag;
  logic                   take_req;
  logic                   is_hit;
  logic                   last_line;
  logic                   unused_ofs;

  assign req_tag    = req_addr[23:Ofs];
  assign unused_ofs = ^req_addr[Ofs-1:0];
  // A pending request is older than one arriving now, so it is served first.
  assign sel_tag    = pend_q ? pend_tag_q : req_tag;
  assign take_req   = req_rd | pend_q;
  assign is_hit     = PF_ENABLE && pf_valid_q && (pf_tag_q == sel_tag);
  assign next_tag   = cur_tag_q + 1'b1;
  assign last_line  = &cur_tag_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      gap_wait_q <= 1'b0;
      cur_tag_q  <= '0;
      pf_tag_q   <= '0;
      pf_line_q  <= '0;
      pf_valid_q <= 1'b0;
      pend_q     <= 1'b0;
      pend_tag_q <= '0;
      req_done   <= 1'b0;
      req_line   <= '0;
      fr_addr    <= '0;
      fr_rd      <= 1'b0;
      pf_hit     <= 1'b0;
    end else begin
      req_done <= 1'b0;
      fr_rd    <= 1'b0;
      pf_hit   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (take_req) begin
            cur_tag_q <= sel_tag;
            // A fresh request arriving behind a pending one stays queued.
            pend_q    <= pend_q & req_rd;
            if (pend_q) begin
              pend_tag_q <= req_tag;
            end
            if (is_hit) begin
              req_line   <= pf_line_q;
              req_done   <= 1'b1;
              pf_hit     <= 1'b1;
              gap_wait_q <= 1'b1;
              state_q    <= StDgap;
            end else begin
              fr_rd      <= 1'b1;
              fr_addr    <= {sel_tag, {Ofs{1'b0}}};
              pf_valid_q <= 1'b0;
              state_q    <= StDem;
            end
          end
        end

        StDem: begin
          if (fr_done) begin
            req_line   <= fr_line;
            req_done   <= 1'b1;
            gap_wait_q <= 1'b0;
            state_q    <= StDgap;
          end
        end

        StDgap: begin
          // After a demand fill, hold off one more cycle so the prefetch read lands
          // two cycles after req_done; after a hit the read follows immediately.
          if (!PF_ENABLE || last_line) begin
            state_q <= StIdle;
          end else if (!gap_wait_q) begin
            gap_wait_q <= 1'b1;
          end else begin
            fr_rd   <= 1'b1;
            fr_addr <= {next_tag, {Ofs{1'b0}}};
            state_q <= StPref;
          end
        end

        StPref: begin
          if (fr_done) begin
            pf_line_q  <= fr_line;
            pf_tag_q   <= next_tag;
            pf_valid_q <= 1'b1;
            state_q    <= StPgap;
          end
        end

        StPgap: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase

      if (req_rd && (state_q != StIdle)) begin
        pend_q     <= 1'b1;
        pend_tag_q <= req_tag;
      end
    end
  end

endmodule
